bsg_reset_sequencer_async: RTL and testbench
============================================

# bsg_reset_sequencer_async

Generates staged, active-high reset outputs for a set of downstream clock-domain partitions. Each output drives the `async_reset_i` of asynchronously reset registers. Assertion is immediate and asynchronous. Deassertion is synchronised to `clk_i` and released one partition at a time with a fixed spacing. It sits directly upstream of the async-reset flop banks and also accepts a software-requested reset through a valid/ready handshake.

## Interface
- `num_domains_p`, 4: number of staged reset outputs (>=1).
- `sync_stages_p`, 2: synchroniser depth for reset deassertion (>=2).
- `delay_cycles_p`, 16: cycles between successive releases (>=1).
- `hold_cycles_p`, 8: cycles all outputs stay asserted after a soft reset (>=1).

Ports:
- `clk_i`  in  1  clock.
- `async_reset_n_i`  in  1  reset; asynchronous, active-low.
- `soft_reset_v_i`  in  1  soft reset request.
- `soft_reset_ready_o`  out  1  soft reset accepted when valid and ready are both high.
- `reset_o`  out  `num_domains_p`  active-high resets; bit 0 is released first.
- `done_o`  out  1  all domains released.

## Operation
- **States:** eSync, eRelease, eHold, eDone.
- **Hard reset:** while `async_reset_n_i`=0, the block asynchronously forces:
  - `reset_o`=all 1s, `done_o`=0, `soft_reset_ready_o`=0;
  - state=eSync, release index=0, counter=0;
  - synchroniser flops=0.
- **eSync:** the synchroniser shifts in 1s. On the edge where its output first goes 1, move to eRelease with counter=0.
- **eRelease:**
  - The counter increments each cycle.
  - When the counter reaches `delay_cycles_p`-1, clear `reset_o[idx]`, increment idx and zero the counter.
  - On releasing idx=`num_domains_p`-1, go to eDone and set `done_o`=1 on the same edge.
- **eDone:**
  - `soft_reset_ready_o`=1, registered so it rises the cycle after entry.
  - `reset_o`=0 and `done_o`=1.
- **Soft reset handshake** (`soft_reset_v_i` & `soft_reset_ready_o` at an edge H), at H:
  - `reset_o`=all 1s, `done_o`=0, ready=0;
  - state=eHold, counter=0, idx=0.
- **eHold:** count `hold_cycles_p` cycles, then go to eRelease with counter=0. The synchroniser is not re-run.
- `soft_reset_v_i` is ignored outside eDone because ready=0 there. No request is queued.
- **Reset mid-sequence:** `async_reset_n_i` falling in any state forces the hard-reset values immediately, without waiting for a clock edge. Already-released domains are re-asserted.
- `reset_o` bits are monotonic during a release sequence: once cleared, a bit stays 0 until the next hard or soft reset.
- **Counter width:** `$clog2(max(delay_cycles_p, hold_cycles_p)+1)`. The counter never wraps because it is cleared on each terminal count.

## Timing
- Edge 1 is the first rising `clk_i` edge after `async_reset_n_i` rises.
- Synchroniser output is 1 after edge S=`sync_stages_p`.
- With D=`delay_cycles_p` and N=`num_domains_p`:
  - `reset_o[k]` falls after edge S+(k+1)·D;
  - `done_o` rises after edge S+N·D;
  - `soft_reset_ready_o` rises one cycle later.
- After soft handshake at edge H:
  - all `reset_o` are high after edge H;
  - `reset_o[k]` falls after edge H+`hold_cycles_p`+(k+1)·D;
  - `done_o` rises after edge H+`hold_cycles_p`+N·D.
- All outputs are driven directly from flops, with no combinational paths from inputs to outputs.
- Every flop uses async reset on `async_reset_n_i`.

## Structure
- **Shared package `bsg_reset_sequencer_pkg`:** state enum `bsg_reset_seq_state_e` (eSync, eRelease, eHold, eDone) and the counter-width helper function.
- **Sub-module `bsg_reset_sync_deassert`:** a `sync_stages_p`-deep chain of async-reset flops with D=1 and output=last stage.
- **Top level:** FSM, counter, index register and `reset_o` register.

## Test plan
All scenarios use N=4, S=2, D=16, hold=8.
- **Power-on:** release reset before edge 1.
  - `reset_o` is 1111 through edge 17, then 1110 after edge 18, 1100 after 34, 1000 after 50, 0000 after 66.
  - `done_o`=1 after edge 66; ready=1 after edge 67.
- **Soft reset:** handshake at edge 100.
  - `reset_o`=1111 and `done_o`=0 after edge 100.
  - `reset_o[0]` falls after 124, `reset_o[3]` after 172; `done_o` rises after 172.
- **Ignored request:** hold `soft_reset_v_i`=1 from edge 5 to 40.
  - Sequence timing is identical to the power-on case.
  - No handshake occurs until ready rises after edge 67, and it fires at edge 67+1 if valid is still high.
- **Mid-sequence hard reset:** assert `async_reset_n_i`=0 between edges 40 and 41, when `reset_o`=1100.
  - `reset_o` goes to 1111 immediately, without waiting for a clock edge.
  - On release, the full power-on timing repeats.
- **Reset during eHold:** hard reset in the middle of eHold.
  - Outputs go to the hard-reset values at once.
  - The synchroniser re-runs on release.
- **Parameter corners:** N=1, D=1, hold=1, S=2.
  - `reset_o[0]` falls after edge 3 and `done_o` rises after edge 3.
  - After a soft handshake at H, release happens after edge H+2.

Source files
------------

// File: rtl/bsg_reset_sequencer_pkg.sv
// Shared types for the staged reset sequencer: FSM state encoding and
// the sizing helper for the release/hold counter.
package bsg_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        eSync,
        eRelease,
        eHold,
        eDone
    } bsg_reset_seq_state_e;

    // One counter serves both the release spacing and the soft-reset hold,
    // so it is sized for whichever terminal count is larger.
    function automatic int counter_width(input int delay_cycles, input int hold_cycles);
        int max_cycles;
        max_cycles = (delay_cycles > hold_cycles) ? delay_cycles : hold_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/bsg_reset_sequencer_if.sv
// Soft-reset handshake plus the staged reset/done outputs of the sequencer.
// The sequencer is the slave; whoever requests soft resets is the master.
interface bsg_reset_sequencer_if #(
    parameter int num_domains_p = 4
);

    logic                     soft_reset_v_i;
    logic                     soft_reset_ready_o;
    logic [num_domains_p-1:0] reset_o;
    logic                     done_o;

    modport master (
        output soft_reset_v_i,
        input  soft_reset_ready_o,
        input  reset_o,
        input  done_o
    );

    modport slave (
        input  soft_reset_v_i,
        output soft_reset_ready_o,
        output reset_o,
        output done_o
    );

endinterface

// File: rtl/bsg_reset_sync_deassert.sv
// Deassertion synchroniser: a chain of async-reset flops shifting in 1s, so
// reset asserts immediately but is seen released only after the chain fills.
module bsg_reset_sync_deassert #(
    parameter int sync_stages_p = 2
) (
    input  logic clk_i,
    input  logic async_reset_n_i,
    output logic sync,
    output logic sync_next
);

    logic [sync_stages_p-1:0] stage_q;

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[sync_stages_p-2:0], 1'b1};
        end
    end

    // sync_next lets the sequencer act on the same edge the output rises.
    assign sync      = stage_q[sync_stages_p-1];
    assign sync_next = stage_q[sync_stages_p-2];

endmodule

// File: rtl/bsg_reset_sequencer_async.sv
// Staged reset sequencer: asserts every domain reset asynchronously, then
// releases them one at a time, spaced by a fixed number of clock cycles.
module bsg_reset_sequencer_async
    import bsg_reset_sequencer_pkg::*;
#(
    parameter int num_domains_p  = 4,
    parameter int sync_stages_p  = 2,
    parameter int delay_cycles_p = 16,
    parameter int hold_cycles_p  = 8
) (
    input  logic                 clk_i,
    input  logic                 async_reset_n_i,
    bsg_reset_sequencer_if.slave seq
);

    localparam int cnt_width_lp = counter_width(delay_cycles_p, hold_cycles_p);
    localparam int idx_width_lp = $clog2(num_domains_p + 1);

    localparam logic [cnt_width_lp-1:0] delay_last_lp = cnt_width_lp'(delay_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] hold_last_lp  = cnt_width_lp'(hold_cycles_p - 1);
    localparam logic [idx_width_lp-1:0] idx_last_lp   = idx_width_lp'(num_domains_p - 1);

    bsg_reset_seq_state_e     state_q;
    logic [cnt_width_lp-1:0]  cnt_q;
    logic [idx_width_lp-1:0]  idx_q;
    logic [num_domains_p-1:0] reset_q;
    logic                     done_q;
    logic                     ready_q;

    logic                     sync;
    logic                     sync_next;
    logic                     handshake;
    logic [num_domains_p-1:0] release_mask;

    bsg_reset_sync_deassert #(
        .sync_stages_p(sync_stages_p)
    ) sync_deassert (
        .clk_i          (clk_i),
        .async_reset_n_i(async_reset_n_i),
        .sync           (sync),
        .sync_next      (sync_next)
    );

    assign handshake    = seq.soft_reset_v_i & ready_q;
    assign release_mask = num_domains_p'(1) << idx_q;

    // Released bits are only ever cleared through release_mask, so reset_o
    // stays monotonic until the next hard or soft reset sets it back to all 1s.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q <= eSync;
            cnt_q   <= '0;
            idx_q   <= '0;
            reset_q <= '1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                eSync: begin
                    if (sync_next && !sync) begin
                        state_q <= eRelease;
                        cnt_q   <= '0;
                    end
                end

                eRelease: begin
                    if (cnt_q == delay_last_lp) begin
                        reset_q <= reset_q & ~release_mask;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + idx_width_lp'(1);
                        if (idx_q == idx_last_lp) begin
                            state_q <= eDone;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + cnt_width_lp'(1);
                    end
                end

                eHold: begin
                    if (cnt_q == hold_last_lp) begin
                        state_q <= eRelease;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_width_lp'(1);
                    end
                end

                eDone: begin
                    // Soft reset skips the synchroniser: the clock is already
                    // running cleanly, only the domains need re-resetting.
                    if (handshake) begin
                        state_q <= eHold;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        reset_q <= '1;
                        done_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= eSync;
                end
            endcase
        end
    end

    assign seq.reset_o            = reset_q;
    assign seq.done_o             = done_q;
    assign seq.soft_reset_ready_o = ready_q;

endmodule

// File: tb/tb_bsg_reset_sequencer_async.sv
// Randomised scoreboard bench for the staged reset sequencer, run on the
// default configuration and on the minimal corner configuration side by side.
module tb_bsg_reset_sequencer_async;

    localparam int N0 = 4, S0 = 2, D0 = 16, H0 = 8;
    localparam int N1 = 1, S1 = 2, D1 = 1,  H1 = 1;
    localparam int num_cycles = 4000;

    typedef struct packed {
        logic [3:0] rst;
        logic       done;
        logic       ready;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic soft_v = 1'b0;

    int   checks = 0;
    int   errors = 0;
    bit   driving_done = 1'b0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    always #5 clk = ~clk;

    bsg_reset_sequencer_if #(.num_domains_p(N0)) bus0 ();
    bsg_reset_sequencer_if #(.num_domains_p(N1)) bus1 ();

    assign bus0.soft_reset_v_i = soft_v;
    assign bus1.soft_reset_v_i = soft_v;

    bsg_reset_sequencer_async #(
        .num_domains_p(N0), .sync_stages_p(S0), .delay_cycles_p(D0), .hold_cycles_p(H0)
    ) dut0 (
        .clk_i          (clk),
        .async_reset_n_i(rst_n),
        .seq            (bus0)
    );

    bsg_reset_sequencer_async #(
        .num_domains_p(N1), .sync_stages_p(S1), .delay_cycles_p(D1), .hold_cycles_p(H1)
    ) dut1 (
        .clk_i          (clk),
        .async_reset_n_i(rst_n),
        .seq            (bus1)
    );

    // Timeline model: base is the edge from which releases are counted
    // (S after power-on, H+hold after a soft handshake at edge H).
    function automatic exp_t model(input int e, input int base, input int n, input int d);
        exp_t x;
        x.rst = '0;
        for (int k = 0; k < n; k++) begin
            x.rst[k] = (e < base + (k + 1) * d);
        end
        x.done  = (e >= base + n * d);
        x.ready = (e >= base + n * d + 1);
        return x;
    endfunction

    function automatic exp_t hard_exp(input int n);
        exp_t x;
        x.rst = '0;
        for (int k = 0; k < n; k++) begin
            x.rst[k] = 1'b1;
        end
        x.done  = 1'b0;
        x.ready = 1'b0;
        return x;
    endfunction

    task automatic check_output(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got reset=%b done=%b ready=%b, expected reset=%b done=%b ready=%b",
                     name, $time, got.rst, got.done, got.ready, exp.rst, exp.done, exp.ready);
        end
    endtask

    // Driver: after each edge, advance the model, push expectations, then
    // randomly apply async resets and pick the next soft request value.
    task automatic apply_stimulus();
        int   edge_cnt   = 0;
        int   base0      = S0;
        int   base1      = S1;
        int   reset_left = 3;
        exp_t last0      = hard_exp(N0);
        exp_t last1      = hard_exp(N1);

        for (int cyc = 0; cyc < num_cycles; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                edge_cnt++;
                if (soft_v && last0.ready) base0 = edge_cnt + H0;
                if (soft_v && last1.ready) base1 = edge_cnt + H1;
                last0 = model(edge_cnt, base0, N0, D0);
                last1 = model(edge_cnt, base1, N1, D1);
                if ($urandom_range(0, 199) == 0) begin
                    rst_n      = 1'b0;
                    reset_left = $urandom_range(1, 3);
                    last0      = hard_exp(N0);
                    last1      = hard_exp(N1);
                end
            end else begin
                last0 = hard_exp(N0);
                last1 = hard_exp(N1);
                reset_left--;
                if (reset_left == 0) begin
                    rst_n    = 1'b1;
                    edge_cnt = 0;
                    base0    = S0;
                    base1    = S1;
                end
            end
            exp_q0.push_back(last0);
            exp_q1.push_back(last1);
            soft_v = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        #1;
        driving_done = 1'b1;
    endtask

    initial begin
        apply_stimulus();
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: sample mid-cycle, away from the active edge.
    initial begin
        exp_t got;
        exp_t exp;
        while (!driving_done) begin
            @(negedge clk);
            if (exp_q0.size() != 0) begin
                exp       = exp_q0.pop_front();
                got.rst   = 4'(bus0.reset_o);
                got.done  = bus0.done_o;
                got.ready = bus0.soft_reset_ready_o;
                check_output("default_cfg", got, exp);
            end
            if (exp_q1.size() != 0) begin
                exp       = exp_q1.pop_front();
                got.rst   = 4'(bus1.reset_o);
                got.done  = bus1.done_o;
                got.ready = bus1.soft_reset_ready_o;
                check_output("corner_cfg", got, exp);
            end
        end
    end

endmodule
